axis_rx_deframer: RTL
=====================

AXIS_RX_DEFRAMER -- requirements
Module: axis_rx_deframer

Interface
REQ-001 SHALL have parameter CHANNEL, default 1, selecting the forwarded channel: 0 = left word, 1 = right word.
REQ-002 SHALL have parameter OUT_W, default 32, giving the output width; legal range 24..32.
REQ-003 SHALL have parameter DEPTH, default 4, giving FIFO depth; power of two, 2..16.
REQ-004 SHALL use one clock and a synchronous, active-high reset: axis_clk  in  1  sole clock, all logic on rising edge.
REQ-005 axis_reset  in  1  synchronous, active-high reset.
REQ-006 s_axis_data  in  32  packet word; bits [23:0] hold a signed 24-bit sample, bits [31:24] are ignored.
REQ-007 s_axis_valid  in  1  AXIS slave valid.
REQ-008 s_axis_ready  out  1  AXIS slave ready.
REQ-009 s_axis_last  in  1  marks the right-channel (second) word of a 2-word packet.
REQ-010 m_axis_data  out  OUT_W  sign-extended sample.
REQ-011 m_axis_valid  out  1  AXIS master valid.
REQ-012 m_axis_ready  in  1  AXIS master ready.
REQ-013 frame_err  out  1  one-cycle pulse on a packet framing violation.
REQ-014 ovf_count  out  16  count of samples dropped because the FIFO was full; saturates.
REQ-015 fill  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 SHALL drive s_axis_ready = 1 every cycle except while axis_reset = 1; the block never backpressures, because the upstream source drops frames.
REQ-017 SHALL count a slave beat only when s_axis_valid and s_axis_ready are both 1.
REQ-018 SHALL implement a 2-state FSM: WAIT_L, then WAIT_R.
  - WAIT_L, beat with last = 0: latch data[23:0] as left, go to WAIT_R.
  - WAIT_L, beat with last = 1: pulse frame_err, discard the word, stay in WAIT_L.
  - WAIT_R, beat with last = 1: latch the word as right, commit the packet, go to WAIT_L.
  - WAIT_R, beat with last = 0: pulse frame_err, replace the latched left word with this word, stay in WAIT_R.
REQ-019 On commit, SHALL push the selected channel word into the FIFO: the right word if CHANNEL = 1, the latched left word if CHANNEL = 0.
  - The pushed value is sign-extended from bit 23 to OUT_W bits.
  - The push happens in the same cycle as the committing beat.
REQ-020 SHALL register frame_err, asserting it the cycle after the offending beat, for exactly one cycle per offending beat.
REQ-021 SHALL implement the FIFO in first-word-fall-through form.
  - m_axis_valid = (fill != 0).
  - m_axis_data = head entry.
  - Latency: the first cycle with m_axis_valid = 1 is the cycle after the committing beat.
REQ-022 SHALL pop the FIFO when m_axis_valid and m_axis_ready are both 1.
  - m_axis_data SHALL stay stable while m_axis_valid = 1 and m_axis_ready = 0.
REQ-023 Push with fill < DEPTH SHALL succeed.
REQ-024 Push with fill = DEPTH and a same-cycle pop SHALL succeed; fill stays at DEPTH.
REQ-025 Push with fill = DEPTH and no pop SHALL drop the sample, increment ovf_count by 1, and leave the FIFO contents unchanged.
REQ-026 ovf_count SHALL saturate at 16'hFFFF; no wrap-around.
REQ-027 Pointers SHALL wrap modulo DEPTH.
  - fill increments on push-only, decrements on pop-only, and is unchanged on push+pop.
REQ-028 Pop with fill = 0 SHALL not occur, because m_axis_valid is 0; the FIFO SHALL ignore m_axis_ready while empty.

Reset
REQ-029 While axis_reset = 1 on a clock edge, the block SHALL reset to:
  - FSM = WAIT_L
  - fill = 0
  - FIFO pointers = 0
  - ovf_count = 0
  - frame_err = 0
  - m_axis_valid = 0
  - s_axis_ready = 0
  - latched left word = 0
REQ-030 Reset asserted mid-packet (FSM in WAIT_R) SHALL discard the half-received packet; the first beat after reset is treated as a left word.
REQ-031 Reset SHALL flush any buffered samples; FIFO RAM contents need not be cleared.
REQ-032 All outputs SHALL be glitch-free registers, except m_axis_data, which is RAM/mux read of the head entry.

Verification
REQ-033 CHANNEL = 1, packet {L = 0x000123, R = 0xFFF000}, m_axis_ready = 1 -> one output beat m_axis_data = 0xFFFFF000 one cycle after the R beat; frame_err stays 0.
REQ-034 CHANNEL = 0, packet {L = 0x800000, R = 0x7FFFFF} -> output 0xFF800000.
REQ-035 m_axis_ready = 0, 6 valid packets, DEPTH = 4 -> fill = 4, ovf_count = 2; releasing ready yields packets 1..4 in order.
REQ-036 Beat sequence last = 1, then last = 0, last = 0, last = 1 -> two frame_err pulses; one output equal to the selected word of the final pair (left = 3rd beat).
REQ-037 fill = 4 with a simultaneous pop and commit -> ovf_count unchanged, fill stays 4, output order preserved.
REQ-038 Reset asserted for 1 cycle after a left beat, then packet {L = 0x000005, R = 0x000006} -> exactly one output 0x00000006, no frame_err; ovf_count forced to 0xFFFF plus one overflow stays 0xFFFF.

Source files
------------

// File: rtl/axis_rx_deframer.sv
// axis_rx_deframer
// Receives 2-word (left, right) AXI-Stream packets carrying signed 24-bit
// samples. One channel of each well-formed packet is sign-extended to OUT_W
// bits and buffered in a first-word-fall-through FIFO. The input never
// backpressures. Framing violations produce a one-cycle frame_err pulse.
// Samples that arrive while the FIFO is full are dropped and counted.
module axis_rx_deframer #(
  parameter int CHANNEL = 1,   // 0 = forward left word, 1 = forward right word
  parameter int OUT_W   = 32,  // 24..32
  parameter int DEPTH   = 4    // power of two, 2..16
) (
  input  logic                       axis_clk,
  input  logic                       axis_reset,
  input  logic [31:0]                s_axis_data,
  input  logic                       s_axis_valid,
  output logic                       s_axis_ready,
  input  logic                       s_axis_last,
  output logic [OUT_W-1:0]           m_axis_data,
  output logic                       m_axis_valid,
  input  logic                       m_axis_ready,
  output logic                       frame_err,
  output logic [15:0]                ovf_count,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);

  typedef enum logic {
    WAIT_L = 1'b0,
    WAIT_R = 1'b1
  } state_t;

  state_t                state;
  logic [23:0]           left_q;

  logic                  beat;
  logic                  commit;
  logic                  bad_beat;
  logic                  pop;
  logic                  is_full;
  logic                  push_ok;
  logic                  push_ovf;
  logic [23:0]           sel_sample;
  logic [OUT_W-1:0]      push_data;
  logic [FILL_W-1:0]     fill_next;

  logic [OUT_W-1:0]      ram [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // Bits [31:24] of each word carry no sample information.
  logic                  unused_hi_bits;
  assign unused_hi_bits = &{1'b0, s_axis_data[31:24]};

  // Beat qualification and packet classification.
  assign beat     = s_axis_valid & s_axis_ready;
  assign commit   = beat && (state == WAIT_R) && s_axis_last;
  assign bad_beat = beat && (((state == WAIT_L) &&  s_axis_last) ||
                             ((state == WAIT_R) && !s_axis_last));

  // The committing beat carries the right word; the left word was latched earlier.
  assign sel_sample = (CHANNEL == 1) ? s_axis_data[23:0] : left_q;
  assign push_data  = OUT_W'($signed(sel_sample));

  // FIFO push/pop decisions. A full FIFO still accepts a push when the head
  // leaves in the same cycle, since the write lands in the slot being freed.
  assign pop      = m_axis_valid & m_axis_ready;
  assign is_full  = (fill == FULL_LVL);
  assign push_ok  = commit && (!is_full || pop);
  assign push_ovf = commit && is_full && !pop;

  // Next occupancy: up on push-only, down on pop-only, unchanged otherwise.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    fill_next = fill;
    unique case ({push_ok, pop})
      2'b10:   fill_next = fill + 1'b1;
      2'b01:   fill_next = fill - 1'b1;
      default: fill_next = fill;
    endcase
  end

  // Packet framing FSM with registered ready and error pulse.
  always_ff @(posedge axis_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (axis_reset) begin
      state        <= WAIT_L;
      left_q       <= '0;
      frame_err    <= 1'b0;
      s_axis_ready <= 1'b0;
    end else begin
      s_axis_ready <= 1'b1;
      frame_err    <= bad_beat;
      if (beat) begin
        unique case (state)
          WAIT_L: begin
            if (!s_axis_last) begin
              left_q <= s_axis_data[23:0];
              state  <= WAIT_R;
            end
          end
          WAIT_R: begin
            if (s_axis_last) begin
              state  <= WAIT_L;
            end else begin
              // A second left word replaces the first; keep waiting for right.
              left_q <= s_axis_data[23:0];
            end
          end
          default: state <= WAIT_L;
        endcase
      end
    end
  end

  // FIFO pointers, occupancy and registered output valid.
  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill         <= '0;
      m_axis_valid <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      fill         <= fill_next;
      m_axis_valid <= (fill_next != '0);
    end
  end

  // FIFO storage write port.
  always_ff @(posedge axis_clk) begin
    // NOTE: storage is deliberately not reset; emptiness is tracked by fill
    // and the pointers, so stale contents are never presented as valid.
    if (push_ok) ram[wr_ptr] <= push_data;
  end

  // Overflow counter, saturating at all-ones.
  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      ovf_count <= '0;
    end else if (push_ovf && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end

  // First-word-fall-through read: head entry is always presented.
  assign m_axis_data = ram[rd_ptr];

endmodule
